// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
//
// Bundles every signal between the writeback arbiter and its neighbours.
//
//   Integer pipe source : ip_wb_dst/result/pc/wb_en/valid -> arbiter,
//                         ip_wb_ready <- arbiter
//   Load/store source   : lsp_ix_dst/result/pc/wb_en/valid -> arbiter,
//                         lsp_ix_ready <- arbiter
//   Regfile write port  : rf_wr_en/dst/data
//   Forward bus         : wb_fwd_valid/dst/data (copies of the regfile write)
//   Retirement          : retire_valid/pc, instret (64-bit retired count)
//
// Modports:
//   slave  - the arbiter itself (consumes results, drives write/retire).
//   master - the surrounding pipeline (produces results, observes outputs).
// ---------------------------------------------------------------------------
interface wb_arbiter_if;

  // Integer pipe result stream
  logic [4:0]  ip_wb_dst;
  logic [63:0] ip_wb_result;
  logic [63:0] ip_wb_pc;
  logic        ip_wb_wb_en;
  logic        ip_wb_valid;
  logic        ip_wb_ready;

  // Load/store pipe result stream
  logic [4:0]  lsp_ix_dst;
  logic [63:0] lsp_ix_result;
  logic [63:0] lsp_ix_pc;
  logic        lsp_ix_wb_en;
  logic        lsp_ix_valid;
  logic        lsp_ix_ready;

  // Register-file write port
  logic        rf_wr_en;
  logic [4:0]  rf_wr_dst;
  logic [63:0] rf_wr_data;

  // Bypass / forward bus
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_dst;
  logic [63:0] wb_fwd_data;

  // Retirement
  logic        retire_valid;
  logic [63:0] retire_pc;
  logic [63:0] instret;

  modport slave (
    input  ip_wb_dst, ip_wb_result, ip_wb_pc, ip_wb_wb_en, ip_wb_valid,
    output ip_wb_ready,
    input  lsp_ix_dst, lsp_ix_result, lsp_ix_pc, lsp_ix_wb_en, lsp_ix_valid,
    output lsp_ix_ready,
    output rf_wr_en, rf_wr_dst, rf_wr_data,
    output wb_fwd_valid, wb_fwd_dst, wb_fwd_data,
    output retire_valid, retire_pc, instret
  );

  modport master (
    output ip_wb_dst, ip_wb_result, ip_wb_pc, ip_wb_wb_en, ip_wb_valid,
    input  ip_wb_ready,
    output lsp_ix_dst, lsp_ix_result, lsp_ix_pc, lsp_ix_wb_en, lsp_ix_valid,
    input  lsp_ix_ready,
    input  rf_wr_en, rf_wr_dst, rf_wr_data,
    input  wb_fwd_valid, wb_fwd_dst, wb_fwd_data,
    input  retire_valid, retire_pc, instret
  );

endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Writeback stage. Merges the integer-pipe and load/store-pipe result
// streams onto the single register-file write port, registers the winner
// for one cycle and drives the regfile write, the forward bus and
// retirement. Keeps a 64-bit retired-instruction counter.
//
// Parameters:
//   RR_EN - 1: round-robin between the two sources when both are valid.
//           0: fixed priority, load/store pipe wins.
//
// Ports:
//   clk - clock
//   rst - synchronous, active-high reset
//   bus - wb_arbiter_if.slave: both source streams, regfile write port,
//         forward bus, retirement outputs and instret.
//
// Timing: grant/ready is combinational from valid in the same cycle; the
// accepted result appears on rf_wr_* / retire_* exactly one cycle later.
// The output stage never stalls, so one result is accepted every cycle
// that any source is valid.
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  // Which source was granted most recently; only consulted on a tie.
  typedef enum logic {
    SRC_IP  = 1'b0,
    SRC_LSP = 1'b1
  } src_e;

  src_e        r_rr_last;
  logic        r_rf_wr_en;
  logic [4:0]  r_rf_wr_dst;
  logic [63:0] r_rf_wr_data;
  logic        r_retire_valid;
  logic [63:0] r_retire_pc;
  logic [63:0] r_instret;

  logic        w_grant_ip;
  logic        w_grant_lsp;
  logic        w_xfer;
  logic [4:0]  w_dst;
  logic [63:0] w_data;
  logic [63:0] w_pc;
  logic        w_wb_en;

  // -------------------------------------------------------------------------
  // Grant. Depends only on the valids and r_rr_last, never on any ready, so
  // there is no combinational loop back into the sources. Both grants are
  // forced low during reset so nothing is accepted in that cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; otherwise an unassigned path infers a latch.
    w_grant_ip  = 1'b0;
    w_grant_lsp = 1'b0;
    if (!rst) begin
      if (bus.ip_wb_valid && bus.lsp_ix_valid) begin
        // Tie: round-robin hands the slot to whoever did not win last time;
        // fixed priority always favours the load/store pipe.
        if (RR_EN && (r_rr_last == SRC_LSP)) begin
          w_grant_ip = 1'b1;
        end else begin
          w_grant_lsp = 1'b1;
        end
      end else if (bus.ip_wb_valid) begin
        w_grant_ip = 1'b1;
      end else if (bus.lsp_ix_valid) begin
        w_grant_lsp = 1'b1;
      end
    end
  end

  assign w_xfer = w_grant_ip | w_grant_lsp;

  // Payload mux: select the granted source. When nothing is granted the
  // values are don't-care because the holding registers are not loaded.
  always_comb begin
    w_dst   = bus.ip_wb_dst;
    w_data  = bus.ip_wb_result;
    w_pc    = bus.ip_wb_pc;
    w_wb_en = bus.ip_wb_wb_en;
    if (w_grant_lsp) begin
      w_dst   = bus.lsp_ix_dst;
      w_data  = bus.lsp_ix_result;
      w_pc    = bus.lsp_ix_pc;
      w_wb_en = bus.lsp_ix_wb_en;
    end
  end

  // -------------------------------------------------------------------------
  // Output register stage.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the payload holding registers are reset too; they are a few
      // flops, not a memory, and a defined value after reset is cheap.
      r_rr_last      <= SRC_IP;
      r_rf_wr_en     <= 1'b0;
      r_rf_wr_dst    <= '0;
      r_rf_wr_data   <= '0;
      r_retire_valid <= 1'b0;
      r_retire_pc    <= '0;
      r_instret      <= '0;
    end else begin
      r_retire_valid <= w_xfer;
      // x0 is hard-wired zero: such a write still retires but is never
      // committed or advertised on the forward bus. Stores have wb_en=0.
      r_rf_wr_en     <= w_xfer && w_wb_en && (w_dst != 5'd0);
      if (w_xfer) begin
        r_rf_wr_dst  <= w_dst;
        r_rf_wr_data <= w_data;
        r_retire_pc  <= w_pc;
        r_rr_last    <= w_grant_lsp ? SRC_LSP : SRC_IP;
      end
      // Counts the instruction being registered now, so instret already
      // includes it in the cycle retire_valid is shown. Wraps naturally.
      r_instret      <= r_instret + {63'd0, w_xfer};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The forward bus is an exact copy of the regfile write port.
  // -------------------------------------------------------------------------
  assign bus.ip_wb_ready  = w_grant_ip;
  assign bus.lsp_ix_ready = w_grant_lsp;

  assign bus.rf_wr_en     = r_rf_wr_en;
  assign bus.rf_wr_dst    = r_rf_wr_dst;
  assign bus.rf_wr_data   = r_rf_wr_data;

  assign bus.wb_fwd_valid = r_rf_wr_en;
  assign bus.wb_fwd_dst   = r_rf_wr_dst;
  assign bus.wb_fwd_data  = r_rf_wr_data;

  assign bus.retire_valid = r_retire_valid;
  assign bus.retire_pc    = r_retire_pc;
  assign bus.instret      = r_instret;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Two arbiters side by side: dut_rr (round-robin) and dut_fp (fixed
// priority). Each directed step drives the sources at the falling edge,
// checks the combinational readies against the grant the step names, and
// pushes the result that grant must produce onto a scoreboard queue. After
// the next rising edge the entry is popped and compared with the outputs.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int GNT_NONE = 0;
  localparam int GNT_IP   = 1;
  localparam int GNT_LSP  = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] pc;
    logic        wb_en;
  } src_t;

  typedef struct packed {
    logic        d;
    logic        rv;
    logic [63:0] pc;
    logic        we;
    logic [4:0]  dst;
    logic [63:0] data;
    logic [63:0] instret;
  } exp_t;

  logic clk;
  logic rst;

  wb_arbiter_if bus_rr ();
  wb_arbiter_if bus_fp ();

  wb_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  wb_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per DUT (index 0 = dut_rr, 1 = dut_fp)
  src_t s_ip  [2];
  src_t s_lsp [2];

  // Reference state per DUT
  logic [4:0]  m_dst     [2];
  logic [63:0] m_data    [2];
  logic [63:0] m_pc      [2];
  logic [63:0] m_instret [2];

  exp_t sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus_rr.ip_wb_valid   = s_ip[0].valid;
    bus_rr.ip_wb_dst     = s_ip[0].dst;
    bus_rr.ip_wb_result  = s_ip[0].result;
    bus_rr.ip_wb_pc      = s_ip[0].pc;
    bus_rr.ip_wb_wb_en   = s_ip[0].wb_en;
    bus_rr.lsp_ix_valid  = s_lsp[0].valid;
    bus_rr.lsp_ix_dst    = s_lsp[0].dst;
    bus_rr.lsp_ix_result = s_lsp[0].result;
    bus_rr.lsp_ix_pc     = s_lsp[0].pc;
    bus_rr.lsp_ix_wb_en  = s_lsp[0].wb_en;
    bus_fp.ip_wb_valid   = s_ip[1].valid;
    bus_fp.ip_wb_dst     = s_ip[1].dst;
    bus_fp.ip_wb_result  = s_ip[1].result;
    bus_fp.ip_wb_pc      = s_ip[1].pc;
    bus_fp.ip_wb_wb_en   = s_ip[1].wb_en;
    bus_fp.lsp_ix_valid  = s_lsp[1].valid;
    bus_fp.lsp_ix_dst    = s_lsp[1].dst;
    bus_fp.lsp_ix_result = s_lsp[1].result;
    bus_fp.lsp_ix_pc     = s_lsp[1].pc;
    bus_fp.lsp_ix_wb_en  = s_lsp[1].wb_en;
  endtask

  task automatic get_ready(input int d, output logic ip_rdy,
                           output logic lsp_rdy);
    if (d == 0) begin
      ip_rdy  = bus_rr.ip_wb_ready;
      lsp_rdy = bus_rr.lsp_ix_ready;
    end else begin
      ip_rdy  = bus_fp.ip_wb_ready;
      lsp_rdy = bus_fp.lsp_ix_ready;
    end
  endtask

  // Pop one scoreboard entry and compare it with the DUT it names.
  task automatic pop_compare(input string tag);
    exp_t        e;
    logic        rv, we, fv;
    logic [4:0]  dst, fdst;
    logic [63:0] data, fdata, pc, cnt;
    string       who;
    e = sb_q.pop_front();
    if (e.d == 1'b0) begin
      rv = bus_rr.retire_valid; pc = bus_rr.retire_pc; we = bus_rr.rf_wr_en;
      dst = bus_rr.rf_wr_dst; data = bus_rr.rf_wr_data;
      fv = bus_rr.wb_fwd_valid; fdst = bus_rr.wb_fwd_dst;
      fdata = bus_rr.wb_fwd_data; cnt = bus_rr.instret;
      who = "rr";
    end else begin
      rv = bus_fp.retire_valid; pc = bus_fp.retire_pc; we = bus_fp.rf_wr_en;
      dst = bus_fp.rf_wr_dst; data = bus_fp.rf_wr_data;
      fv = bus_fp.wb_fwd_valid; fdst = bus_fp.wb_fwd_dst;
      fdata = bus_fp.wb_fwd_data; cnt = bus_fp.instret;
      who = "fp";
    end
    check({tag, "/", who, "/retire_valid"}, {63'd0, rv}, {63'd0, e.rv});
    check({tag, "/", who, "/retire_pc"}, pc, e.pc);
    check({tag, "/", who, "/rf_wr_en"}, {63'd0, we}, {63'd0, e.we});
    check({tag, "/", who, "/rf_wr_dst"}, {59'd0, dst}, {59'd0, e.dst});
    check({tag, "/", who, "/rf_wr_data"}, data, e.data);
    check({tag, "/", who, "/fwd_valid"}, {63'd0, fv}, {63'd0, e.we});
    check({tag, "/", who, "/fwd_dst"}, {59'd0, fdst}, {59'd0, e.dst});
    check({tag, "/", who, "/fwd_data"}, fdata, e.data);
    check({tag, "/", who, "/instret"}, cnt, e.instret);
  endtask

  // One cycle on DUT d with the named expected grant. Called at a falling
  // edge with s_ip/s_lsp already set up.
  task automatic step(input string tag, input int d, input int g);
    logic ip_rdy, lsp_rdy;
    src_t w;
    exp_t e;
    apply();
    #1;
    get_ready(d, ip_rdy, lsp_rdy);
    check({tag, "/ip_ready"},  {63'd0, ip_rdy},  {63'd0, (g == GNT_IP)});
    check({tag, "/lsp_ready"}, {63'd0, lsp_rdy}, {63'd0, (g == GNT_LSP)});
    e.d = d[0];
    if (g == GNT_NONE) begin
      e.rv = 1'b0;
      e.we = 1'b0;
    end else begin
      w = (g == GNT_IP) ? s_ip[d] : s_lsp[d];
      e.rv = 1'b1;
      e.we = w.wb_en && (w.dst != 5'd0);
      m_dst[d]     = w.dst;
      m_data[d]    = w.result;
      m_pc[d]      = w.pc;
      m_instret[d] = m_instret[d] + 64'd1;
    end
    e.dst     = m_dst[d];
    e.data    = m_data[d];
    e.pc      = m_pc[d];
    e.instret = m_instret[d];
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    pop_compare(tag);
  endtask

  // One reset cycle with whatever the sources currently drive: readies must
  // be low on both DUTs and everything must read zero afterwards.
  task automatic reset_step(input string tag);
    logic ip_rdy, lsp_rdy;
    exp_t e;
    rst = 1'b1;
    apply();
    #1;
    for (int d = 0; d < 2; d++) begin
      get_ready(d, ip_rdy, lsp_rdy);
      check({tag, "/ip_ready"},  {63'd0, ip_rdy},  64'd0);
      check({tag, "/lsp_ready"}, {63'd0, lsp_rdy}, 64'd0);
      m_dst[d] = '0; m_data[d] = '0; m_pc[d] = '0; m_instret[d] = '0;
      e = '0;
      e.d = d[0];
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    pop_compare(tag);
    pop_compare(tag);
    rst = 1'b0;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      s_ip[d]  = '0;
      s_lsp[d] = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    apply();

    // Reset state
    reset_step("reset");

    // IP alone
    s_ip[0] = '{valid: 1'b1, dst: 5'd5, result: 64'h1234,
                pc: 64'h8000_0000, wb_en: 1'b1};
    step("ip_alone", 0, GNT_IP);
    idle_all();
    step("idle_hold", 0, GNT_NONE);

    // Round-robin, both valid for 4 cycles
    reset_step("reset_rr");
    s_ip[0]  = '{1'b1, 5'd3, 64'hA1, 64'h1000, 1'b1};
    s_lsp[0] = '{1'b1, 5'd4, 64'hB1, 64'h2000, 1'b1};
    step("rr_c1", 0, GNT_LSP);
    s_lsp[0] = '{1'b1, 5'd6, 64'hB2, 64'h2004, 1'b1};
    step("rr_c2", 0, GNT_IP);
    s_ip[0]  = '{1'b1, 5'd8, 64'hA2, 64'h1004, 1'b1};
    step("rr_c3", 0, GNT_LSP);
    s_lsp[0] = '{1'b1, 5'd10, 64'hB3, 64'h2008, 1'b1};
    step("rr_c4", 0, GNT_IP);
    idle_all();
    step("rr_idle", 0, GNT_NONE);

    // Fixed priority: LSP wins 4 cycles, IP (held) retires on cycle 5
    reset_step("reset_fp");
    s_ip[1] = '{1'b1, 5'd9, 64'hC1, 64'h3000, 1'b1};
    for (int k = 0; k < 4; k++) begin
      s_lsp[1] = '{1'b1, 5'(12 + k), 64'hD0 + 64'(k), 64'h4000 + 64'(4 * k),
                   1'b1};
      step($sformatf("fp_c%0d", k + 1), 1, GNT_LSP);
    end
    s_lsp[1] = '0;
    step("fp_c5", 1, GNT_IP);
    idle_all();
    step("fp_idle", 1, GNT_NONE);

    // Store retires without a register write; x0 write retires silently
    s_lsp[0] = '{1'b1, 5'd7, 64'hDEAD, 64'h100, 1'b0};
    step("store", 0, GNT_LSP);
    idle_all();
    s_ip[0]  = '{1'b1, 5'd0, 64'h55, 64'h104, 1'b1};
    step("x0_write", 0, GNT_IP);
    idle_all();

    // instret wrap
    force dut_rr.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut_rr.r_instret;
    m_instret[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    s_ip[0] = '{1'b1, 5'd2, 64'h77, 64'h200, 1'b1};
    step("wrap", 0, GNT_IP);
    idle_all();

    // Reset with a registered result in flight and a source still valid
    s_ip[0] = '{1'b1, 5'd11, 64'h99, 64'h300, 1'b1};
    step("pre_rst", 0, GNT_IP);
    reset_step("mid_rst");
    idle_all();
    step("post_rst", 0, GNT_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly downstream of the load/store pipeline and the integer pipeline.
- Merges both result streams onto the single register-file write port.
- Registers the winning result for one cycle and drives the regfile write, the bypass/forward bus and retirement.
- Maintains a 64-bit retired-instruction counter.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, LSP first.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ip_wb_dst  in  5  integer pipe destination register
- ip_wb_result  in  64  integer pipe result
- ip_wb_pc  in  64  integer pipe instruction PC
- ip_wb_wb_en  in  1  integer pipe writes register
- ip_wb_valid  in  1  integer pipe result valid
- ip_wb_ready  out  1  integer pipe result accepted
- lsp_ix_dst  in  5  LSP destination register
- lsp_ix_result  in  64  LSP load data, already extended
- lsp_ix_pc  in  64  LSP instruction PC
- lsp_ix_wb_en  in  1  LSP writes register (0 for stores)
- lsp_ix_valid  in  1  LSP result valid
- lsp_ix_ready  out  1  LSP result accepted
- rf_wr_en  out  1  regfile write strobe
- rf_wr_dst  out  5  regfile write index
- rf_wr_data  out  64  regfile write data
- wb_fwd_valid  out  1  forward bus valid (== rf_wr_en)
- wb_fwd_dst  out  5  forward bus index (== rf_wr_dst)
- wb_fwd_data  out  64  forward bus data (== rf_wr_data)
- retire_valid  out  1  one instruction retired this cycle
- retire_pc  out  64  PC of retired instruction
- instret  out  64  retired-instruction count

Behaviour:
- Clock and reset:
  - Single clock clk; rst is synchronous, active-high.
  - Reset values: rf_wr_en=0, rf_wr_dst=0, rf_wr_data=0, retire_valid=0, retire_pc=0, instret=0, rr_last=0 (0 = IP granted last).
- Grant (combinational, same cycle as valid):
  - Only one source valid: that source is granted.
  - Both valid, RR_EN=1: grant the source not named by rr_last.
  - Both valid, RR_EN=0: grant LSP.
  - Neither valid: no grant.
- Ready outputs:
  - ip_wb_ready = grant_ip; lsp_ix_ready = grant_lsp.
  - Ready depends on valid only, never the reverse.
  - Never both ready in one cycle.
  - The output stage never stalls, so an idle source is not starved beyond one cycle under RR_EN=1.
- Transfer happens on valid&&ready. On the next clock edge:
  - retire_valid=1 and retire_pc=granted pc.
  - rf_wr_en = wb_en && (dst!=0).
  - rf_wr_dst and rf_wr_data are loaded from the granted source.
  - rr_last is set to the granted source.
- Cycle with no transfer: rf_wr_en=0 and retire_valid=0 next cycle. rf_wr_dst, rf_wr_data and retire_pc hold their values.
- Latency: exactly 1 cycle from handshake to rf_wr_en/retire_valid. Throughput is 1 result per cycle in total.
- Register x0:
  - A write to dst=0 with wb_en=1 still retires.
  - rf_wr_en stays 0, so forward never advertises x0.
- Stores (wb_en=0): retire with rf_wr_en=0.
- instret:
  - Increments by 1 on every cycle retire_valid is high.
  - Wraps from 2^64-1 to 0.
  - Not affected by wb_en.
- Reset mid-stream:
  - In-flight registered result is dropped (rf_wr_en=0 next cycle); instret cleared.
  - Readies are 0 during the reset cycle.
- Sources must hold payload stable while valid && !ready. The block does not check this.

Test Plan:
- Reset, then IP valid alone (dst=5, result=0x1234, pc=0x80000000, wb_en=1) -> ip_wb_ready=1 same cycle; next cycle rf_wr_en=1, rf_wr_dst=5, rf_wr_data=0x1234, retire_pc=0x80000000, instret=1.
- Both valid for 4 cycles with RR_EN=1, rr_last=0 after reset -> grants alternate LSP, IP, LSP, IP; instret=4.
- Same stimulus with RR_EN=0 -> LSP granted all 4 cycles; ip_wb_ready held 0; IP data retires on cycle 5 once LSP drops valid.
- LSP store (wb_en=0, dst=7, pc=0x100) -> retire_valid=1, retire_pc=0x100, rf_wr_en=0. IP write to dst=0 with wb_en=1 -> retire_valid=1, rf_wr_en=0.
- Preload instret=0xFFFF_FFFF_FFFF_FFFF via a bench force, then one retire -> instret=0.
- Assert rst while a transfer is in progress -> next cycle rf_wr_en=0, retire_valid=0, instret=0, both readies 0 during reset.
